// File: rtl/add_sub_pkg.sv
// Shared constants for the registered add/subtract datapath element.
package add_sub_pkg;

    localparam int unsigned ADD_SUB_WIDTH = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam logic [ADD_SUB_WIDTH-1:0] S_RST     = '0;
    localparam logic                     OVF_RST   = 1'b0;
    localparam logic                     CARRY_RST = 1'b0;
    localparam logic                     ZERO_RST  = 1'b1;

endpackage

// File: rtl/add_sub_full_adder.sv
// One-bit full adder; one stage of the ripple-carry chain in add_sub.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_sub.sv
// Registered two's-complement adder/subtractor with signed overflow.
// Define ADD_SUB_FLAGS_EN to add the registered carry and zero outputs.
module add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             overflow,
`ifdef ADD_SUB_FLAGS_EN
    output logic             carry,
    output logic             zero,
`endif
    output logic [WIDTH-1:0] S
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;

    // Subtract as A + ~B + 1 through the same chain: invert B, carry in m.
    assign b_eff = B ^ {WIDTH{m}};
    assign c[0]  = m;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S        <= WIDTH'(S_RST);
            overflow <= OVF_RST;
        end else begin
            S        <= sum;
            overflow <= c[WIDTH] ^ c[WIDTH-1];
        end
    end

`ifdef ADD_SUB_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= CARRY_RST;
            zero  <= ZERO_RST;
        end else begin
            carry <= c[WIDTH];
            zero  <= (sum == '0);
        end
    end
`endif

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed table, random vectors, reset sequences.
module tb_add_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] S;
    logic       overflow;
`ifdef ADD_SUB_FLAGS_EN
    logic       carry;
    logic       zero;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    add_sub #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m        (m),
        .A        (A),
        .B        (B),
        .overflow (overflow),
`ifdef ADD_SUB_FLAGS_EN
        .carry    (carry),
        .zero     (zero),
`endif
        .S        (S)
    );

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       ovf;
        logic       carry;
        logic       zero;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       ovf;
        logic       carry;
        logic       zero;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, " S"}, 32'(S), 32'(e.s));
        check({tag, " overflow"}, 32'(overflow), 32'(e.ovf));
`ifdef ADD_SUB_FLAGS_EN
        check({tag, " carry"}, 32'(carry), 32'(e.carry));
        check({tag, " zero"}, 32'(zero), 32'(e.zero));
`endif
    endtask

    // Drive one triple at the falling edge, then compare one edge later.
    task automatic apply(input string tag, input logic mi, input logic [7:0] ai,
                         input logic [7:0] bi, input exp_t e);
        exp_t got;
        @(negedge clk);
        m = mi; A = ai; B = bi;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check_outputs(tag, got);
        end
    endtask

    // Independent reference using signed integer arithmetic.
    function automatic exp_t model(input logic mi, input logic [7:0] ai, input logic [7:0] bi);
        exp_t e;
        int   r;
        logic [8:0] u;
        if (mi) begin
            r = int'($signed(ai)) - int'($signed(bi));
            u = {1'b0, ai} + {1'b0, ~bi} + 9'd1;
        end else begin
            r = int'($signed(ai)) + int'($signed(bi));
            u = {1'b0, ai} + {1'b0, bi};
        end
        e.s     = u[7:0];
        e.carry = u[8];
        e.ovf   = (r > 127) || (r < -128);
        e.zero  = (u[7:0] == 8'h00);
        return e;
    endfunction

    vec_t vecs[13];
    exp_t rst_exp;
    exp_t e;

    initial begin
        vecs[0]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h6C, 8'hCA, 8'hA2, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h40, 8'h3F, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
        rst_exp  = '{8'h00, 1'b0, 1'b0, 1'b1};

        // Reset held with live operands: outputs stay at reset values.
        rst_n = 1'b0; m = 1'b0; A = 8'h7F; B = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset hold", rst_exp);

        // Release between edges: 7F+01 appears exactly one edge later.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("release", '{8'h80, 1'b1, 1'b0, 1'b0});

        // Input changes between edges must not reach the outputs.
        A = 8'h01; B = 8'h01; m = 1'b1;
        #3;
        check_outputs("hold between edges", '{8'h80, 1'b1, 1'b0, 1'b0});

        for (int i = 0; i < 13; i++) begin
            e = '{vecs[i].s, vecs[i].ovf, vecs[i].carry, vecs[i].zero};
            apply($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, e);
        end

        for (int i = 0; i < 200; i++) begin
            logic       rm;
            logic [7:0] ra;
            logic [7:0] rb;
            rm = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            apply($sformatf("rand%0d", i), rm, ra, rb, model(rm, ra, rb));
        end

        // Mid-stream reset discards the in-flight result.
        @(negedge clk);
        m = 1'b0; A = 8'h7F; B = 8'h01; rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("midstream reset", rst_exp);
        exp_q.delete();

        @(negedge clk);
        rst_n = 1'b1;
        m = 1'b1; A = 8'h6C; B = 8'hCA;
        @(posedge clk);
        #1;
        check_outputs("after midstream reset", '{8'hA2, 1'b1, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
